// File: rtl/matvec_stream_tx.sv
// matvec_stream_tx
// Fetches a command's elements from a synchronous-read operand memory and
// streams them onto the matvec8 input interface, one element per cycle
// while input_ready stays high.
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous active-low reset
//   cmd_valid        command offered
//   cmd_ready        idle, command can be accepted
//   cmd_load_matrix  1: K*K matrix elements then K vector elements; 0: K vector elements
//   cmd_base_addr    memory address of element 0
//   mem_rd_en        memory read strobe
//   mem_addr         memory read address (0 when not reading)
//   mem_rd_data      read data, valid the cycle after mem_rd_en
//   input_valid      element valid toward matvec
//   input_ready      matvec accepts the element
//   input_data       element value (0 when input_valid=0)
//   new_matrix       element belongs to a new matrix (0 when input_valid=0)
//   busy             command in progress
//   done             one-cycle pulse after the final handshake
module matvec_stream_tx #(
  parameter int K      = 8,
  parameter int IN_W   = 14,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load_matrix,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [IN_W-1:0]   mem_rd_data,
  output logic              input_valid,
  input  logic              input_ready,
  output logic [IN_W-1:0]   input_data,
  output logic              new_matrix,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NMAT  = K * K;
  localparam int unsigned NFULL = K * K + K;
  localparam int unsigned CW    = $clog2(NFULL + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic              load_q;
  logic [CW-1:0]     len_q, rd_cnt_q, tx_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              infl_q, infl_nm_q;
  logic [1:0]        cnt_q;
  logic [IN_W-1:0]   d0_q, d1_q;
  logic              n0_q, n1_q;
  logic              done_q;

  logic              accept, pop, popf, push, last, rd_nm, wr_slot;
  logic [1:0]        occ;

  // The 2-entry buffer is made of the registered slots plus the read that
  // returns this cycle. When the slots are empty the returning word is shown
  // directly and is only captured if it is not taken in the same cycle.
  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    accept      = 1'b0;
    mem_rd_en   = 1'b0;
    last        = 1'b0;
    input_data  = '0;
    new_matrix  = 1'b0;
    occ         = cnt_q + {1'b0, infl_q};
    input_valid = (cnt_q != 2'd0) || infl_q;
    if (cnt_q != 2'd0) begin
      input_data = d0_q;
      new_matrix = n0_q;
    end else if (infl_q) begin
      input_data = mem_rd_data;
      new_matrix = infl_nm_q;
    end
    pop     = input_valid && input_ready;
    popf    = pop && (cnt_q != 2'd0);
    push    = infl_q && !(pop && (cnt_q == 2'd0));
    wr_slot = (cnt_q - {1'b0, popf}) != 2'd0;
    rd_nm   = load_q && (rd_cnt_q < CW'(NMAT));
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        mem_rd_en = (rd_cnt_q != len_q) && (occ < 2'd2);
        last      = pop && (tx_cnt_q == len_q - CW'(1));
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_addr = mem_rd_en ? addr_q : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      addr_q    <= '0;
      infl_q    <= 1'b0;
      infl_nm_q <= 1'b0;
      cnt_q     <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      n0_q      <= 1'b0;
      n1_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= last;
      infl_q    <= mem_rd_en;
      infl_nm_q <= mem_rd_en && rd_nm;
      cnt_q     <= cnt_q + {1'b0, push} - {1'b0, popf};
      if (accept) begin
        load_q   <= cmd_load_matrix;
        len_q    <= cmd_load_matrix ? CW'(NFULL) : CW'(K);
        rd_cnt_q <= '0;
        tx_cnt_q <= '0;
        addr_q   <= cmd_base_addr;
      end else begin
        if (mem_rd_en) begin
          rd_cnt_q <= rd_cnt_q + CW'(1);
          addr_q   <= addr_q + ADDR_W'(1);
        end
        if (pop) tx_cnt_q <= tx_cnt_q + CW'(1);
      end
      // Shift first; a push into slot 0 in the same cycle overrides it.
      if (popf) begin
        d0_q <= d1_q;
        n0_q <= n1_q;
      end
      if (push) begin
        if (wr_slot) begin
          d1_q <= mem_rd_data;
          n1_q <= infl_nm_q;
        end else begin
          d0_q <= mem_rd_data;
          n0_q <= infl_nm_q;
        end
      end
    end
  end

  assign done = done_q;

endmodule
